cis_line_capture: RTL and testbench
===================================

Name: cis_line_capture

Overview:
Receive-side counterpart of the CIS line controller. Captures digitised CIS pixel samples and delimits lines using the controller's SI_TOGGLE/SI_CNT line markers. Tags each pixel with its colour and start/end-of-line flags, and buffers it in a small first-word-fall-through (FWFT) FIFO. Drives a valid/ready stream toward the line-buffer/USB path.

Parameters:
ADC_W, 8, ADC sample width
PIXELS, 2592, active pixels per line; must match the sensor's LED/pixel count
SKIP_PIX, 60, dummy samples discarded after each line start
FIFO_DEPTH, 16, output FIFO entries (power of 2)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
SI_TOGGLE  in  1  line marker from the controller; each edge (either direction) starts a line
SI_CNT  in  2  colour of the starting line: 0=R, 1=G, 2=B; valid in the same cycle as the toggle edge
ADC_DATA  in  ADC_W  pixel sample
ADC_VALID  in  1  one-cycle strobe per pixel sample
CLR_FLAGS  in  1  one-cycle pulse; clears sticky flags
M_DATA  out  ADC_W  pixel value
M_COLOR  out  2  colour tag
M_SOL  out  1  first active pixel of a line
M_EOL  out  1  last active pixel of a line
M_VALID  out  1  stream valid
M_READY  in  1  stream ready
LINE_CNT  out  16  count of completed lines, wraps at 65535->0
OVERFLOW  out  1  sticky: sample dropped because FIFO was full
SHORT_LINE  out  1  sticky: new line marker arrived before PIXELS samples were captured

Behaviour:
- Reset: state IDLE; FIFO empty; M_VALID=0; M_DATA, M_COLOR, M_SOL, M_EOL=0; LINE_CNT=0; OVERFLOW=0; SHORT_LINE=0; skip and pixel counters=0.
- Edge detect: SI_TOGGLE is registered once; an edge is toggle_q != SI_TOGGLE. On an edge, SI_CNT is latched as the line colour. SI_CNT=3 is latched unchanged.
- State machine:
  - IDLE -> SKIP on an edge.
  - SKIP: count ADC_VALID strobes. After SKIP_PIX strobes -> CAPTURE. With SKIP_PIX=0, go straight to CAPTURE in the edge cycle.
  - CAPTURE: each ADC_VALID strobe pushes {data, colour, sol, eol}.
    - sol=1 on pixel index 0.
    - eol=1 on index PIXELS-1; that push moves to IDLE and increments LINE_CNT.
- Edge during SKIP or CAPTURE: restart SKIP with the new colour, counters cleared.
  - Edge during CAPTURE: set SHORT_LINE; no EOL is emitted for the truncated line; LINE_CNT unchanged.
- ADC_VALID in the same cycle as an edge: sample belongs to the new line (counted as skip index 0, or as pixel 0 if SKIP_PIX=0).
- Latency: a sample strobed at cycle n is registered at n+1 and visible at M_* at n+2 if the FIFO was empty (FWFT).
- Stream rules:
  - Transfer occurs when M_VALID & M_READY.
  - M_* stay stable while M_VALID=1 and M_READY=0.
  - Push and pop in the same cycle when full is allowed; the push is accepted.
- Full FIFO with no pop: the sample is dropped and OVERFLOW is set.
  - Pixel counter still advances, so line framing stays aligned.
  - A dropped SOL/EOL entry is lost. LINE_CNT still increments on the index-PIXELS-1 strobe.
- Sticky flags: CLR_FLAGS clears both. A set condition in the same cycle as CLR_FLAGS wins (flag=1).
- RST mid-line: FIFO flushed, M_VALID=0 in the next cycle; partial line discarded.
- Counters are wide enough for PIXELS and SKIP_PIX (ceil log2). LINE_CNT wraps.

Optional Feature:
CIS_TEST_PATTERN_EN
- Defined: captured data is replaced by pixel index[ADC_W-1:0] XOR {colour, zeros}. Timing, flags and strobes are unchanged; ADC_DATA is ignored.
- Undefined: ADC_DATA is passed through; no pattern logic is present.

Test Plan:
- PIXELS=8, SKIP_PIX=2, M_READY=1; one SI_TOGGLE edge with SI_CNT=0, then 12 ADC_VALID strobes with data 0..11 -> 8 beats of data 2..9, colour 0, SOL on 2, EOL on 9; LINE_CNT=1; strobes 10 and 11 ignored (IDLE).
- Three lines with SI_CNT 0,1,2 -> colours tagged R,G,B in order; LINE_CNT=3; no flags set.
- Edge after 4 captured pixels -> SHORT_LINE=1; new line SOL follows; no EOL for the first line; LINE_CNT=0.
- FIFO_DEPTH=4, M_READY=0, one full line -> 4 entries held, OVERFLOW=1, LINE_CNT=1. Release M_READY -> exactly 4 beats, data 2..5, SOL on the first, no EOL.
- Single strobe with FIFO empty at cycle n in CAPTURE -> M_VALID rises at n+2. M_READY toggled 1/0 -> M_* stable while stalled.
- With CIS_TEST_PATTERN_EN, colour 1, ADC_W=8 -> pixels 0..7 read 0x40..0x47; CLR_FLAGS concurrent with an overflow -> OVERFLOW stays 1.

Source files
------------

// File: rtl/cis_line_capture.sv
// CIS line capture: frames ADC samples into lines using SI_TOGGLE markers and streams tagged
// pixels through a FWFT FIFO. Define CIS_TEST_PATTERN_EN to replace pixel data with a pattern.
module cis_line_capture #(
  parameter int unsigned ADC_W      = 8,
  parameter int unsigned PIXELS     = 2592,
  parameter int unsigned SKIP_PIX   = 60,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SI_TOGGLE,
  input  logic [1:0]       SI_CNT,
  input  logic [ADC_W-1:0] ADC_DATA,
  input  logic             ADC_VALID,
  input  logic             CLR_FLAGS,
  output logic [ADC_W-1:0] M_DATA,
  output logic [1:0]       M_COLOR,
  output logic             M_SOL,
  output logic             M_EOL,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [15:0]      LINE_CNT,
  output logic             OVERFLOW,
  output logic             SHORT_LINE
);

  localparam int unsigned PixW  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int unsigned SkipW = (SKIP_PIX > 1) ? $clog2(SKIP_PIX) : 1;
  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned EntW  = ADC_W + 4;
  localparam logic [PixW-1:0]  PixLast  = PixW'(PIXELS - 1);
  localparam logic [SkipW-1:0] SkipLast = SkipW'(SKIP_PIX - 1);
  localparam logic [AddrW:0]   FifoFull = (AddrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StSkip, StCapture} state_e;

  state_e             state_q, state_d, cur_st;
  logic               toggle_q, edge_det;
  logic [1:0]         color_q, color_d;
  logic [SkipW-1:0]   skip_q, skip_d, cur_skip;
  logic [PixW-1:0]    pix_q, pix_d, cur_pix;
  logic [15:0]        line_q, line_d;
  logic               ovf_q, ovf_d, short_q, short_d;
  logic               stg_vld_q, stg_vld_d;
  logic [EntW-1:0]    stg_ent_q, stg_ent_d;
  logic [ADC_W-1:0]   cap_data;
  logic               sol, eol, push;
  logic [EntW-1:0]    mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]     count_q, count_d;
  logic               full, pop, wr_en, ovf_set;

  assign edge_det = toggle_q != SI_TOGGLE;

  always_comb begin
    // An edge restarts framing in the same cycle, so a coincident strobe joins the new line.
    cur_st   = state_q;
    cur_skip = skip_q;
    cur_pix  = pix_q;
    color_d  = color_q;
    short_d  = short_q & ~CLR_FLAGS;
    if (edge_det) begin
      color_d  = SI_CNT;
      cur_skip = '0;
      cur_pix  = '0;
      cur_st   = (SKIP_PIX == 0) ? StCapture : StSkip;
      if (state_q == StCapture) short_d = 1'b1;
    end
    state_d = cur_st;
    skip_d  = cur_skip;
    pix_d   = cur_pix;
    line_d  = line_q;
    push    = 1'b0;
    sol     = 1'b0;
    eol     = 1'b0;
    unique case (cur_st)
      StSkip: begin
        if (ADC_VALID) begin
          if (cur_skip == SkipLast) begin
            state_d = StCapture;
            skip_d  = '0;
          end else begin
            skip_d = cur_skip + SkipW'(1);
          end
        end
      end
      StCapture: begin
        if (ADC_VALID) begin
          push = 1'b1;
          sol  = cur_pix == '0;
          eol  = cur_pix == PixLast;
          if (eol) begin
            state_d = StIdle;
            pix_d   = '0;
            line_d  = line_q + 16'd1;
          end else begin
            pix_d = cur_pix + PixW'(1);
          end
        end
      end
      default: ;
    endcase
`ifdef CIS_TEST_PATTERN_EN
    cap_data = ADC_W'(cur_pix) ^ {color_d, {(ADC_W - 2){1'b0}}};
`else
    cap_data = ADC_DATA;
`endif
    stg_vld_d = push;
    stg_ent_d = {cap_data, color_d, sol, eol};
  end

  always_comb begin
    full     = count_q == FifoFull;
    pop      = (count_q != '0) & M_READY;
    wr_en    = stg_vld_q & (~full | pop);
    ovf_set  = stg_vld_q & full & ~pop;
    ovf_d    = (ovf_q & ~CLR_FLAGS) | ovf_set;
    wr_ptr_d = wr_ptr_q + (wr_en ? AddrW'(1) : AddrW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? AddrW'(1) : AddrW'(0));
    count_d  = count_q;
    if (wr_en & ~pop) count_d = count_q + (AddrW + 1)'(1);
    else if (pop & ~wr_en) count_d = count_q - (AddrW + 1)'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      toggle_q  <= 1'b0;
      color_q   <= 2'd0;
      skip_q    <= '0;
      pix_q     <= '0;
      line_q    <= 16'd0;
      ovf_q     <= 1'b0;
      short_q   <= 1'b0;
      stg_vld_q <= 1'b0;
      stg_ent_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      toggle_q  <= SI_TOGGLE;
      color_q   <= color_d;
      skip_q    <= skip_d;
      pix_q     <= pix_d;
      line_q    <= line_d;
      ovf_q     <= ovf_d;
      short_q   <= short_d;
      stg_vld_q <= stg_vld_d;
      stg_ent_q <= stg_ent_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= stg_ent_q;
  end

  always_comb begin
    M_VALID = count_q != '0;
    {M_DATA, M_COLOR, M_SOL, M_EOL} = M_VALID ? mem_q[rd_ptr_q] : '0;
  end

  assign LINE_CNT   = line_q;
  assign OVERFLOW   = ovf_q;
  assign SHORT_LINE = short_q;

endmodule

// File: tb/tb_cis_line_capture.sv
// Scoreboard bench for cis_line_capture (PIXELS=8, SKIP_PIX=2, FIFO_DEPTH=4).
module tb_cis_line_capture;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SI_TOGGLE = 1'b0;
  logic [1:0] SI_CNT = 2'd0;
  logic [7:0] ADC_DATA = 8'd0;
  logic       ADC_VALID = 1'b0;
  logic       CLR_FLAGS = 1'b0;
  logic       M_READY = 1'b1;
  logic [7:0] M_DATA;
  logic [1:0] M_COLOR;
  logic       M_SOL, M_EOL, M_VALID;
  logic [15:0] LINE_CNT;
  logic       OVERFLOW, SHORT_LINE;

  int compared = 0;
  int mismatched = 0;
  logic [11:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [11:0] prev_ent = '0;

  cis_line_capture #(
    .ADC_W(8), .PIXELS(8), .SKIP_PIX(2), .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .RST(RST), .SI_TOGGLE(SI_TOGGLE), .SI_CNT(SI_CNT), .ADC_DATA(ADC_DATA),
    .ADC_VALID(ADC_VALID), .CLR_FLAGS(CLR_FLAGS), .M_DATA(M_DATA), .M_COLOR(M_COLOR),
    .M_SOL(M_SOL), .M_EOL(M_EOL), .M_VALID(M_VALID), .M_READY(M_READY), .LINE_CNT(LINE_CNT),
    .OVERFLOW(OVERFLOW), .SHORT_LINE(SHORT_LINE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] ed(input logic [7:0] adc, input int idx, input logic [1:0] col);
`ifdef CIS_TEST_PATTERN_EN
    ed = 8'(idx) ^ {col, 6'b0};
`else
    ed = adc;
`endif
  endfunction

  task automatic expect_px(input logic [7:0] adc, input int idx, input logic [1:0] col,
                           input logic sol, input logic eol);
    exp_q.push_back({ed(adc, idx, col), col, sol, eol});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic toggle(input logic [1:0] c);
    SI_TOGGLE = ~SI_TOGGLE;
    SI_CNT    = c;
  endtask

  task automatic strobe(input logic [7:0] d);
    ADC_DATA  = d;
    ADC_VALID = 1'b1;
    tick();
    ADC_VALID = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  // Monitor: pops on each transfer and checks hold-while-stalled.
  always @(negedge CLK) begin
    logic [11:0] cur;
    cur = {M_DATA, M_COLOR, M_SOL, M_EOL};
    if (!RST) begin
      if (prev_stall) begin
        chk("stall_valid", M_VALID, 1);
        chk("stall_hold", cur, prev_ent);
      end
      if (M_VALID && M_READY) begin
        if (exp_q.size() == 0) chk("unexpected_beat", cur, 0);
        else chk("beat", cur, exp_q.pop_front());
      end
    end
    prev_stall = M_VALID && !M_READY && !RST;
    prev_ent   = cur;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    RST = 1'b0;
    tick();
    chk("rst_valid", M_VALID, 0);
    chk("rst_data", {M_DATA, M_COLOR, M_SOL, M_EOL}, 0);
    chk("rst_line_cnt", LINE_CNT, 0);
    chk("rst_flags", {OVERFLOW, SHORT_LINE}, 0);

    // Basic line: 2 skipped, 8 captured, 2 ignored after EOL.
    toggle(2'd0);
    for (int i = 2; i < 10; i++) expect_px(8'(i), i - 2, 2'd0, i == 2, i == 9);
    for (int i = 0; i < 12; i++) strobe(8'(i));
    drain();
    chk("line1_cnt", LINE_CNT, 1);

    // Three lines R, G, B.
    for (int c = 0; c < 3; c++) begin
      toggle(2'(c));
      for (int i = 2; i < 10; i++)
        expect_px(8'(16 * c + i), i - 2, 2'(c), i == 2, i == 9);
      for (int i = 0; i < 10; i++) strobe(8'(16 * c + i));
    end
    drain();
    chk("rgb_line_cnt", LINE_CNT, 4);
    chk("rgb_flags", {OVERFLOW, SHORT_LINE}, 0);

    // Truncated line: edge after 4 captured pixels.
    toggle(2'd1);
    for (int i = 2; i < 6; i++) expect_px(8'(i + 64), i - 2, 2'd1, i == 2, 1'b0);
    for (int i = 0; i < 6; i++) strobe(8'(i + 64));
    toggle(2'd2);
    for (int i = 2; i < 10; i++) expect_px(8'(i + 96), i - 2, 2'd2, i == 2, i == 9);
    strobe(8'd96);
    chk("short_set", SHORT_LINE, 1);
    chk("short_line_cnt", LINE_CNT, 4);
    for (int i = 1; i < 10; i++) strobe(8'(i + 96));
    drain();
    chk("after_short_cnt", LINE_CNT, 5);
    CLR_FLAGS = 1'b1;
    tick();
    CLR_FLAGS = 1'b0;
    chk("short_cleared", SHORT_LINE, 0);

    // Overflow with M_READY low; clear coincides with the final drop.
    M_READY = 1'b0;
    toggle(2'd0);
    for (int i = 2; i < 6; i++) expect_px(8'(i), i - 2, 2'd0, i == 2, 1'b0);
    for (int i = 0; i < 10; i++) strobe(8'(i));
    CLR_FLAGS = 1'b1;
    tick();
    CLR_FLAGS = 1'b0;
    tick();
    chk("ovf_sticky", OVERFLOW, 1);
    chk("ovf_line_cnt", LINE_CNT, 6);
    chk("ovf_held_valid", M_VALID, 1);
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
      M_READY = ~M_READY;
      tick();
    end
    if (exp_q.size() != 0) chk("release_timeout", exp_q.size(), 0);
    M_READY = 1'b1;
    repeat (4) tick();
    chk("ovf_drained", M_VALID, 0);
    CLR_FLAGS = 1'b1;
    tick();
    CLR_FLAGS = 1'b0;
    chk("ovf_cleared", OVERFLOW, 0);

    // Latency: single strobe into an empty FIFO.
    toggle(2'd1);
    strobe(8'd200);
    strobe(8'd201);
    for (int i = 2; i < 10; i++) expect_px(8'(i + 200), i - 2, 2'd1, i == 2, i == 9);
    ADC_DATA  = 8'd202;
    ADC_VALID = 1'b1;
    tick();
    ADC_VALID = 1'b0;
    chk("lat_n1", M_VALID, 0);
    tick();
    chk("lat_n2", M_VALID, 1);
    for (int i = 3; i < 10; i++) strobe(8'(i + 200));
    drain();
    chk("final_line_cnt", LINE_CNT, 7);
    chk("final_flags", {OVERFLOW, SHORT_LINE}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
